// File: rtl/fast_img_pkg.sv
// Shared image types for the FAST front end: pixel depth, image bounds,
// coordinate/pixel typedefs and the generic pixel request struct.
package fast_img_pkg;

  localparam int PIXEL_DEPTH = 8;
  localparam int X_MAX       = 200;
  localparam int Y_MAX       = 200;
  localparam int XW          = $clog2(X_MAX);
  localparam int YW          = $clog2(Y_MAX);

  typedef logic [XW-1:0]          x_coord_t;
  typedef logic [YW-1:0]          y_coord_t;
  typedef logic [PIXEL_DEPTH-1:0] pixel_t;

  typedef struct packed {
    x_coord_t x;
    y_coord_t y;
    pixel_t   dat;
  } img_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick for the image RAM arbiter; only built with SRAM_ARB_RR_EN.
// Requester a is the writer, b the reader; the pointer records who won the last contention.
`ifdef SRAM_ARB_RR_EN
module rr_pick2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic last_b_q;
  logic last_b_d;
  logic contended;

  // Resetting the pointer to "b won last" hands the first contention to a.
  always_comb begin
    contended = req_a_i & req_b_i & ~rst;
    gnt_a_o   = req_a_i & ~rst & (~req_b_i | last_b_q);
    gnt_b_o   = req_b_i & ~rst & (~req_a_i | ~last_b_q);
    last_b_d  = contended ? ~last_b_q : last_b_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule
`endif

// File: rtl/sram_image_arbiter.sv
// Single-port image RAM arbiter: grants loader writes and fetcher reads, drops
// out-of-bounds coordinates, returns read data two cycles after the grant.
// Define SRAM_ARB_RR_EN for round-robin arbitration instead of fixed write priority.
module sram_image_arbiter #(
  parameter  int PIXEL_DEPTH = fast_img_pkg::PIXEL_DEPTH,
  parameter  int X_MAX       = fast_img_pkg::X_MAX,
  parameter  int Y_MAX       = fast_img_pkg::Y_MAX,
  localparam int XW          = $clog2(X_MAX),
  localparam int YW          = $clog2(Y_MAX)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_req,
  input  logic [XW-1:0]          wr_x,
  input  logic [YW-1:0]          wr_y,
  input  logic [PIXEL_DEPTH-1:0] wr_dat,
  output logic                   wr_gnt,
  output logic                   wr_oob,
  input  logic                   rd_req,
  input  logic [XW-1:0]          rd_x,
  input  logic [YW-1:0]          rd_y,
  output logic                   rd_gnt,
  output logic                   rd_valid,
  output logic [PIXEL_DEPTH-1:0] rd_dat,
  output logic                   rd_oob,
  output logic [XW-1:0]          ram_x_addr,
  output logic [YW-1:0]          ram_y_addr,
  output logic [PIXEL_DEPTH-1:0] ram_wdat,
  output logic                   ram_wen,
  output logic                   ram_ren,
  input  logic [PIXEL_DEPTH-1:0] ram_rdat,
  output logic                   busy
);

  import fast_img_pkg::*;

  localparam logic [XW:0] X_LIM = (XW+1)'(X_MAX);
  localparam logic [YW:0] Y_LIM = (YW+1)'(Y_MAX);

  logic wr_pick;
  logic rd_pick;
  logic wr_oob_now;
  logic rd_oob_now;

  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [PIXEL_DEPTH-1:0] wdat_q, wdat_d;
  logic                   wen_q, wen_d;
  logic                   ren_q, ren_d;
  logic                   wr_oob_q, wr_oob_d;
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_oob_q, s1_oob_d;
  logic                   s2_valid_q, s2_valid_d;
  logic                   s2_oob_q, s2_oob_d;

`ifdef SRAM_ARB_RR_EN
  rr_pick2 u_rr_pick2 (
    .clk     (clk),
    .rst     (rst),
    .req_a_i (wr_req),
    .req_b_i (rd_req),
    .gnt_a_o (wr_pick),
    .gnt_b_o (rd_pick)
  );
`else
  assign wr_pick = wr_req & ~rst;
  assign rd_pick = rd_req & ~wr_req & ~rst;
`endif

  assign wr_gnt     = wr_pick;
  assign rd_gnt     = rd_pick;
  assign wr_oob_now = ({1'b0, wr_x} >= X_LIM) | ({1'b0, wr_y} >= Y_LIM);
  assign rd_oob_now = ({1'b0, rd_x} >= X_LIM) | ({1'b0, rd_y} >= Y_LIM);

  // OOB requests are consumed but never touch the address or strobes.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    wdat_d     = wdat_q;
    wen_d      = 1'b0;
    ren_d      = 1'b0;
    wr_oob_d   = wr_gnt & wr_oob_now;
    s1_valid_d = rd_gnt;
    s1_oob_d   = rd_gnt & rd_oob_now;
    s2_valid_d = s1_valid_q;
    s2_oob_d   = s1_oob_q;
    if (wr_gnt && !wr_oob_now) begin
      x_d    = wr_x;
      y_d    = wr_y;
      wdat_d = wr_dat;
      wen_d  = 1'b1;
    end else if (rd_gnt && !rd_oob_now) begin
      x_d   = rd_x;
      y_d   = rd_y;
      ren_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      wdat_q     <= '0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      wr_oob_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_oob_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_oob_q   <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      wdat_q     <= wdat_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      wr_oob_q   <= wr_oob_d;
      s1_valid_q <= s1_valid_d;
      s1_oob_q   <= s1_oob_d;
      s2_valid_q <= s2_valid_d;
      s2_oob_q   <= s2_oob_d;
    end
  end

  assign ram_x_addr = x_q;
  assign ram_y_addr = y_q;
  assign ram_wdat   = wdat_q;
  assign ram_wen    = wen_q;
  assign ram_ren    = ren_q;
  assign wr_oob     = wr_oob_q;
  assign rd_valid   = s2_valid_q;
  assign rd_oob     = s2_oob_q;
  // Data is forced to zero outside a valid in-bounds return, including right after reset.
  assign rd_dat     = (s2_valid_q && !s2_oob_q) ? ram_rdat : '0;
  assign busy       = s1_valid_q | s2_valid_q;

endmodule
